// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the RISC5 system bus decoder.
//   - bus widths (word address / data)
//   - decoder FSM state encoding
//   - default error read data
//   - default system memory map (slave 0 in the LSBs):
//       0 RAM   byte 0x000000, 1 PROM byte 0xFFE000,
//       2 bio   byte 0xFFFFC4, 3 spare byte 0xFFFFC0
//   - win_hit(): base/mask window compare
package bus_pkg;

  localparam int BUS_AW = 22;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  localparam logic [BUS_DW-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  localparam int MAP_NSLV = 4;
  localparam logic [MAP_NSLV*BUS_AW-1:0] MAP_BASE =
    {22'h3FFFF0, 22'h3FFFF1, 22'h3FF800, 22'h000000};
  localparam logic [MAP_NSLV*BUS_AW-1:0] MAP_MASK =
    {22'h3FFFFF, 22'h3FFFFF, 22'h3FFE00, 22'h3C0000};

  // Address falls inside a window when the masked bits agree.
  function automatic logic win_hit(input logic [BUS_AW-1:0] addr,
                                   input logic [BUS_AW-1:0] base,
                                   input logic [BUS_AW-1:0] mask);
    return ((addr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/bus_dec_if.sv
// bus_dec_if: system bus bundle between CPU/slaves and the decoder.
//   master modport: CPU + slave side (drives strobe/address, slave data/acks,
//                   error-log clear; observes read data, ack, slave strobes,
//                   error log)
//   slave  modport: the decoder's view (directions reversed)
interface bus_dec_if
  import bus_pkg::*;
#(
  parameter int NSLV = 4
) ();

  logic                   bus_stb;
  logic                   bus_we;
  logic [BUS_AW-1:0]      bus_addr;
  logic [BUS_DW-1:0]      bus_din;
  logic                   bus_ack;
  logic [NSLV-1:0]        slv_stb;
  logic [NSLV*BUS_DW-1:0] slv_dout;
  logic [NSLV-1:0]        slv_ack;
  logic                   err_flag;
  logic [BUS_AW-1:0]      err_addr;
  logic                   err_we;
  logic                   err_clr;

  modport master (
    output bus_stb, bus_we, bus_addr, slv_dout, slv_ack, err_clr,
    input  bus_din, bus_ack, slv_stb, err_flag, err_addr, err_we
  );

  modport slave (
    input  bus_stb, bus_we, bus_addr, slv_dout, slv_ack, err_clr,
    output bus_din, bus_ack, slv_stb, err_flag, err_addr, err_we
  );

endinterface

// File: rtl/bus_dec_match.sv
// bus_dec_match: priority address matcher.
//   i_addr    word address from the master
//   o_sel     one-hot winning slave (lowest index wins on overlap)
//   o_any_hit at least one window matches
module bus_dec_match
  import bus_pkg::*;
#(
  parameter int                         NSLV     = 4,
  parameter logic [NSLV*BUS_AW-1:0]     SLV_BASE = MAP_BASE,
  parameter logic [NSLV*BUS_AW-1:0]     SLV_MASK = MAP_MASK
) (
  input  logic [BUS_AW-1:0] i_addr,
  output logic [NSLV-1:0]   o_sel,
  output logic              o_any_hit
);

  logic [NSLV-1:0] w_hit;
  logic [NSLV-1:0] w_sel;
  logic            w_found;

  for (genvar g = 0; g < NSLV; g++) begin : g_hit
    assign w_hit[g] = win_hit(i_addr,
                              SLV_BASE[g*BUS_AW +: BUS_AW],
                              SLV_MASK[g*BUS_AW +: BUS_AW]);
  end

  // Keep only the lowest-index hit.
  always_comb begin
    w_sel   = {NSLV{1'b0}};
    w_found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (w_hit[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end else begin
        w_sel[i] = 1'b0;
      end
    end
  end

  assign o_sel     = w_sel;
  assign o_any_hit = |w_hit;

endmodule

// File: rtl/bus_dec.sv
// bus_dec: RISC5 system bus address decoder and response multiplexer.
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    bus_dec_if.slave: master strobe/we/address, read data/ack back,
//          per-slave strobe/data/ack, error log (flag/addr/we/clr)
// A per-transfer watchdog turns unmapped or hung accesses into a one-cycle
// error response carrying ERR_DATA.
// Optional feature: define BUS_DEC_ERRLOG_EN to build the first-error log;
// otherwise err_flag/err_addr/err_we read 0 and err_clr is ignored.
module bus_dec
  import bus_pkg::*;
#(
  parameter int                     NSLV     = 4,
  parameter logic [NSLV*BUS_AW-1:0] SLV_BASE = MAP_BASE,
  parameter logic [NSLV*BUS_AW-1:0] SLV_MASK = MAP_MASK,
  parameter int                     TIMEOUT  = 255,
  parameter logic [BUS_DW-1:0]      ERR_DATA = ERR_DATA_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  bus_dec_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_TO   = CW'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [NSLV-1:0]   w_sel;
  logic              w_any_hit;
  logic              w_stb;
  logic              w_ack_sel;
  logic              w_enter_err;
  logic [BUS_DW-1:0] w_mux;
  logic [BUS_DW-1:0] w_din;
  logic              w_ack;
  logic [NSLV-1:0]   w_slv_stb;

  bus_dec_match #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_match (
    .i_addr    (bus.bus_addr),
    .o_sel     (w_sel),
    .o_any_hit (w_any_hit)
  );

  // Reset gates the strobe so outputs read idle while rst_n is low.
  assign w_stb       = bus.bus_stb & rst_n;
  assign w_ack_sel   = |(bus.slv_ack & w_sel);
  assign w_enter_err = (w_state_nxt == ST_ERR) && (r_state != ST_ERR);

  // Next state and watchdog counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_stb && !w_any_hit) begin
          w_state_nxt = ST_ERR;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_stb && !w_ack_sel) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      ST_WAIT: begin
        // A dropped strobe or a slave ack ends the transfer; ack beats timeout.
        if (!w_stb || w_ack_sel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_TO) begin
          w_state_nxt = ST_ERR;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt != CNT_MAX) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Read-data mux over the one-hot select.
  always_comb begin
    w_mux = {BUS_DW{1'b0}};
    for (int i = 0; i < NSLV; i++) begin
      if (w_sel[i]) begin
        w_mux = bus.slv_dout[i*BUS_DW +: BUS_DW];
      end else begin
        w_mux = w_mux;
      end
    end
  end

  // Master-facing response and slave strobes.
  always_comb begin
    w_slv_stb = {NSLV{1'b0}};
    w_ack     = 1'b0;
    w_din     = {BUS_DW{1'b0}};
    if (!rst_n) begin
      w_slv_stb = {NSLV{1'b0}};
      w_ack     = 1'b0;
      w_din     = {BUS_DW{1'b0}};
    end else if (r_state == ST_ERR) begin
      w_ack = 1'b1;
      w_din = ERR_DATA;
    end else if (w_stb) begin
      w_slv_stb = w_sel;
      w_ack     = w_ack_sel;
      w_din     = w_mux;
    end else begin
      w_slv_stb = {NSLV{1'b0}};
      w_ack     = 1'b0;
      w_din     = {BUS_DW{1'b0}};
    end
  end

  assign bus.slv_stb = w_slv_stb;
  assign bus.bus_ack = w_ack;
  assign bus.bus_din = w_din;

`ifdef BUS_DEC_ERRLOG_EN
  logic              r_err_flag;
  logic [BUS_AW-1:0] r_err_addr;
  logic              r_err_we;

  // First-error log; a capture coinciding with err_clr takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_flag <= 1'b0;
      r_err_addr <= {BUS_AW{1'b0}};
      r_err_we   <= 1'b0;
    end else if (w_enter_err && (!r_err_flag || bus.err_clr)) begin
      r_err_flag <= 1'b1;
      r_err_addr <= bus.bus_addr;
      r_err_we   <= bus.bus_we;
    end else if (bus.err_clr) begin
      r_err_flag <= 1'b0;
      r_err_addr <= {BUS_AW{1'b0}};
      r_err_we   <= 1'b0;
    end else begin
      r_err_flag <= r_err_flag;
      r_err_addr <= r_err_addr;
      r_err_we   <= r_err_we;
    end
  end

  assign bus.err_flag = r_err_flag;
  assign bus.err_addr = r_err_addr;
  assign bus.err_we   = r_err_we;
`else
  logic w_unused_log;

  assign bus.err_flag = 1'b0;
  assign bus.err_addr = {BUS_AW{1'b0}};
  assign bus.err_we   = 1'b0;
  assign w_unused_log = bus.err_clr ^ bus.bus_we ^ w_enter_err;
`endif

endmodule

// File: tb/tb_bus_dec.sv
// tb_bus_dec: randomized scoreboard bench for bus_dec.
//   Stimulus pushes the expected ack cycle / read data / slave strobes;
//   an independent negedge monitor pops on every bus_ack and compares.
//   Slaves 2 and 3 share a base so the overlap priority is exercised.
module tb_bus_dec;
  import bus_pkg::*;

  localparam int NS    = 4;
  localparam int TO    = 8;
  localparam int NEVER = 1000;
  localparam logic [31:0] EDATA = 32'hDEADBEEF;
  localparam logic [NS*22-1:0] TB_BASE =
    {22'h3FFFF1, 22'h3FFFF1, 22'h3FF800, 22'h000000};
  localparam logic [NS*22-1:0] TB_MASK =
    {22'h3FFFFE, 22'h3FFFFF, 22'h3FFE00, 22'h3C0000};
`ifdef BUS_DEC_ERRLOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  // Reference memory map, slave 0 first.
  logic [21:0] base_tab[NS] = '{22'h000000, 22'h3FF800, 22'h3FFFF1, 22'h3FFFF1};
  logic [21:0] mask_tab[NS] = '{22'h3C0000, 22'h3FFE00, 22'h3FFFFF, 22'h3FFFFE};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_dec_if #(.NSLV(NS)) bif ();

  bus_dec #(
    .NSLV(NS), .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK),
    .TIMEOUT(TO), .ERR_DATA(EDATA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  typedef struct {
    int          cyc;
    logic [31:0] din;
    logic [NS-1:0] stb;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          s_lat[NS];
  logic [31:0] s_data[NS];
  bit          m_flag = 1'b0;
  logic [21:0] m_addr = 22'h0;
  logic        m_we   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_decode(input logic [21:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mask_tab[i]) == (base_tab[i] & mask_tab[i])) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bif.bus_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("bus_din", bif.bus_din, e.din);
        check("ack_slv_stb", 32'(bif.slv_stb), 32'(e.stb));
      end
    end
  end

  task automatic chk_log();
    check("err_flag", 32'(bif.err_flag), LOG_EN ? 32'(m_flag) : 32'h0);
    check("err_addr", 32'(bif.err_addr), LOG_EN ? 32'(m_addr) : 32'h0);
    check("err_we",   32'(bif.err_we),   LOG_EN ? 32'(m_we)   : 32'h0);
  endtask

  task automatic rand_slaves();
    for (int i = 0; i < NS; i++) begin
      s_lat[i]  = $urandom_range(0, 10);
      s_data[i] = {8'(i), 24'($urandom)};
    end
  endtask

  // One transfer; called at posedge+1 and returns at posedge+1.
  task automatic xfer(input logic [21:0] a, input logic w, input bit clr_on_err);
    int            exp_s;
    int            exp_lat;
    bit            is_err;
    int            c;
    bit            done;
    exp_t          e;
    logic [NS-1:0] one;
    one   = 4'b0001;
    exp_s = ref_decode(a);
    if (exp_s < 0) begin
      is_err = 1'b1; exp_lat = 1;
    end else if (s_lat[exp_s] <= TO) begin
      is_err = 1'b0; exp_lat = s_lat[exp_s];
    end else begin
      is_err = 1'b1; exp_lat = TO + 1;
    end
    e.cyc = cyc + exp_lat;
    e.din = is_err ? EDATA : s_data[exp_s];
    e.stb = is_err ? 4'b0000 : (one << exp_s);
    sb.push_back(e);
    bif.bus_addr = a;
    bif.bus_we   = w;
    bif.bus_stb  = 1'b1;
    for (int i = 0; i < NS; i++) bif.slv_dout[i*32 +: 32] = s_data[i];
    c = 0;
    done = 1'b0;
    while (!done) begin
      for (int i = 0; i < NS; i++) bif.slv_ack[i] = (s_lat[i] == c);
      bif.err_clr = clr_on_err && is_err && (c == exp_lat - 1);
      @(negedge clk);
      if (c == 0) check("first_slv_stb", 32'(bif.slv_stb), (exp_s >= 0) ? 32'(one << exp_s) : 32'h0);
      if (bif.bus_ack === 1'b1) begin
        done = 1'b1;
      end else if (c >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_timeout: got no ack expected ack at cycle %0d", e.cyc);
        done = 1'b1;
      end
      @(posedge clk); #1;
      c++;
    end
    bif.bus_stb = 1'b0;
    bif.slv_ack = '0;
    bif.err_clr = 1'b0;
    if (is_err && (!m_flag || clr_on_err)) begin
      m_flag = 1'b1; m_addr = a; m_we = w;
    end
    @(negedge clk);
    chk_log();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    bif.err_clr = 1'b1;
    @(posedge clk); #1;
    bif.err_clr = 1'b0;
    m_flag = 1'b0; m_addr = 22'h0; m_we = 1'b0;
    @(negedge clk);
    chk_log();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    logic [21:0] a;
    int          r;
    bif.bus_stb  = 1'b1;
    bif.bus_we   = 1'b0;
    bif.bus_addr = 22'h000040;
    bif.slv_dout = '1;
    bif.slv_ack  = '1;
    bif.err_clr  = 1'b0;
    for (int i = 0; i < NS; i++) begin s_lat[i] = NEVER; s_data[i] = 32'h0; end

    // Reset: outputs gated off even with strobe and acks high.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_bus_ack", 32'(bif.bus_ack), 32'h0);
    check("rst_slv_stb", 32'(bif.slv_stb), 32'h0);
    check("rst_bus_din", bif.bus_din, 32'h0);
    chk_log();
    @(posedge clk); #1;
    bif.bus_stb = 1'b0;
    bif.slv_ack = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RAM read, slave 0 acks after 3 cycles.
    s_lat  = '{3, NEVER, NEVER, NEVER};
    s_data = '{32'h12345678, 32'h11111111, 32'h22222222, 32'h33333333};
    xfer(22'h000040, 1'b0, 1'b0);
    // Unmapped read.
    xfer(22'h200000, 1'b0, 1'b0);
    clear_log();
    // Hung bio write: timeout.
    xfer(22'h3FFFF1, 1'b1, 1'b0);
    // Consecutive errors keep the first; clear; coincident clear + capture.
    xfer(22'h2AAAAA, 1'b1, 1'b0);
    xfer(22'h155555, 1'b0, 1'b0);
    clear_log();
    xfer(22'h100000, 1'b0, 1'b0);
    xfer(22'h300000, 1'b1, 1'b1);
    // Overlapping windows: slave 2 wins over faster slave 3.
    s_lat  = '{NEVER, NEVER, 2, 1};
    s_data = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    xfer(22'h3FFFF1, 1'b0, 1'b0);
    xfer(22'h3FFFF0, 1'b0, 1'b0);
    // Latency boundaries: same-cycle ack, ack at TIMEOUT, one past it.
    s_lat = '{0, TO, NEVER, NEVER};
    xfer(22'h000123, 1'b1, 1'b0);
    xfer(22'h3FF900, 1'b0, 1'b0);
    s_lat = '{NEVER, TO + 1, NEVER, NEVER};
    xfer(22'h3FF9FF, 1'b0, 1'b0);

    // Reset during WAIT: no ack, log cleared, transfer restarts from IDLE.
    s_lat = '{NEVER, NEVER, NEVER, NEVER};
    bif.bus_addr = 22'h000040;
    bif.bus_we   = 1'b0;
    bif.bus_stb  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bus_ack", 32'(bif.bus_ack), 32'h0);
    check("midrst_slv_stb", 32'(bif.slv_stb), 32'h0);
    check("midrst_bus_din", bif.bus_din, 32'h0);
    @(posedge clk); #1;
    m_flag = 1'b0; m_addr = 22'h0; m_we = 1'b0;
    chk_log();
    rst_n = 1'b1;
    xfer(22'h000040, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      rand_slaves();
      r = $urandom_range(0, 4);
      case (r)
        0: a = 22'($urandom) & 22'h03FFFF;
        1: a = 22'h3FF800 | 22'($urandom_range(0, 511));
        2: a = 22'h3FFFF0;
        3: a = 22'h3FFFF1;
        default: a = 22'($urandom);
      endcase
      xfer(a, 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) clear_log();
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
